// File: rtl/counter_pkg.sv
// Shared types and defaults for the up/down modulo counter and its prescaler.
package counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  localparam int PSC_W_DEFAULT = 4;

endpackage : counter_pkg

// File: rtl/counter_prescaler.sv
// Step-enable prescaler: one tick every prescale_i+1 enabled cycles; clr_i restarts the period.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PSC_W = PSC_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [PSC_W-1:0] prescale_i,
  output logic             tick_o
);

  logic [PSC_W-1:0] psc_q;
  logic [PSC_W-1:0] psc_d;
  logic             tick_s;

  // >= rather than == so that lowering prescale below the running phase still ticks next cycle
  assign tick_s = en_i && (psc_q >= prescale_i);
  assign tick_o = tick_s;

  // Next-state for the phase counter; clr beats en, idle cycles freeze the phase.
  always_comb begin
    psc_d = psc_q;
    if (clr_i) begin
      psc_d = {PSC_W{1'b0}};
    end else if (tick_s) begin
      psc_d = {PSC_W{1'b0}};
    end else if (en_i) begin
      psc_d = psc_q + PSC_W'(1);
    end else begin
      psc_d = psc_q;
    end
  end

  // Phase register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      psc_q <= {PSC_W{1'b0}};
    end else begin
      psc_q <= psc_d;
    end
  end

endmodule : counter_prescaler

// File: rtl/counter_mod.sv
// Up/down modulo counter with wrap/saturate, clamped parallel load, terminal-count pulse,
// sticky overflow and compare match.
module counter_mod
  import counter_pkg::*;
#(
  parameter int WIDTH   = 5,
  parameter int MAX_VAL = 2**WIDTH - 1,
  parameter int PSC_W   = PSC_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             dir_i,
  input  logic             sat_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic [PSC_W-1:0] prescale_i,
  input  logic [WIDTH-1:0] cmp_val_i,
  input  logic             ovf_clr_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             ovf_o,
  output logic             cmp_match_o
);

  localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] val);
    return (val > MAX_C) ? MAX_C : val;
  endfunction

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             tick_s;
  logic             step_s;
  logic             at_bound_s;
  logic             bound_evt_s;
  dir_e             dir_s;
  mode_e            mode_s;

  counter_prescaler #(
    .PSC_W (PSC_W)
  ) u_prescaler (
    .clk        (clk),
    .rst        (rst),
    .en_i       (en_i),
    .clr_i      (load_i),
    .prescale_i (prescale_i),
    .tick_o     (tick_s)
  );

  assign dir_s  = dir_e'(dir_i);
  assign mode_s = mode_e'(sat_i);
  assign step_s = tick_s && !load_i;

  // Boundary detection and next-state for count, tc and ovf.
  always_comb begin
    at_bound_s = 1'b0;
    count_d    = count_q;
    case (dir_s)
      DIR_UP:   at_bound_s = (count_q == MAX_C);
      DIR_DOWN: at_bound_s = (count_q == ZERO_C);
      default:  at_bound_s = 1'b0;
    endcase
    bound_evt_s = step_s && at_bound_s;

    if (load_i) begin
      count_d = clamp_load(load_val_i);
    end else if (step_s) begin
      case (dir_s)
        DIR_UP:   count_d = at_bound_s ? ((mode_s == MODE_SAT) ? MAX_C : ZERO_C)
                                       : count_q + WIDTH'(1);
        DIR_DOWN: count_d = at_bound_s ? ((mode_s == MODE_SAT) ? ZERO_C : MAX_C)
                                       : count_q - WIDTH'(1);
        default:  count_d = count_q;
      endcase
    end else begin
      count_d = count_q;
    end

    tc_d = bound_evt_s;

    // a boundary in the same cycle as a clear must leave the flag set
    if (bound_evt_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= ZERO_C;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o     = count_q;
  assign tc_o        = tc_q;
  assign ovf_o       = ovf_q;
  assign cmp_match_o = (count_q == cmp_val_i);

endmodule : counter_mod

// File: doc/counter_mod.md
Name: counter_mod

Overview:
- Parametrised up/down modulo counter: programmable terminal value, wrap or saturate mode, parallel load, prescaled step enable.
- Reports terminal-count pulse, sticky overflow flag and compare-match output.
- Successor to the free-running 5-bit counter. Used as the general-purpose timer/event counter in tool_check and downstream blocks.

Parameters:
- WIDTH, 5, counter width in bits.
- MAX_VAL, 2**WIDTH-1, highest count value (modulus = MAX_VAL+1). Must satisfy 1 <= MAX_VAL <= 2**WIDTH-1.
- PSC_W, 4, prescaler width in bits.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-low.
- en  in  1  count enable; gates both prescaler and counter.
- dir  in  1  1 = count up, 0 = count down.
- sat  in  1  0 = wrap at boundary, 1 = saturate at boundary.
- load  in  1  parallel load strobe.
- load_val  in  WIDTH  value to load.
- prescale  in  PSC_W  step every prescale+1 enabled cycles.
- cmp_val  in  WIDTH  compare value.
- ovf_clr  in  1  clears sticky overflow.
- count  out  WIDTH  current count, registered.
- tc  out  1  terminal-count pulse, registered, one cycle.
- ovf  out  1  sticky overflow/underflow flag, registered.
- cmp_match  out  1  count == cmp_val, combinational from count register.

Behaviour:
- Reset (rst==0 at posedge):
  - count=0, tc=0, ovf=0, prescaler=0.
  - Overrides every other input.
- Priority per cycle: reset > load > step.
- Load:
  - count <= min(load_val, MAX_VAL).
  - Prescaler cleared to 0; tc=0.
  - ovf unchanged, except for ovf_clr.
  - Load is taken whether en is high or low.
- Prescaler psc_cnt (PSC_W bits):
  - Advances only when en=1 and load=0.
  - tick = en && (psc_cnt >= prescale).
  - On tick, psc_cnt <= 0; otherwise psc_cnt <= psc_cnt+1.
  - prescale=0 gives a tick every enabled cycle.
  - The >= comparison guarantees a tick on the next enabled cycle when prescale is lowered below psc_cnt mid-count.
- Step, taken on tick with load=0:
  - Up, count<MAX_VAL: count+1.
  - Up, count==MAX_VAL: boundary event. count <= 0 in wrap mode, holds MAX_VAL in saturate mode.
  - Down, count>0: count-1.
  - Down, count==0: boundary event. count <= MAX_VAL in wrap mode, holds 0 in saturate mode.
  - Out-of-range count is unreachable, because load is clamped.
- tc:
  - Asserted for exactly the cycle after a step that hits a boundary event; 0 otherwise.
  - In saturate mode, tc re-pulses on every further tick held at the boundary.
- ovf:
  - Set on any boundary event; cleared by ovf_clr.
  - Set and clear in the same cycle: set wins.
- en=0: count, psc_cnt and tc=0 hold/deassert; load, ovf_clr and reset still act.
- dir and sat are sampled on each tick. A change takes effect on the next step with no extra latency.
- Latency: count updates at the posedge on which the tick/load is seen. tc and ovf are visible alongside the updated count.

Decomposition:
- Package counter_pkg holds:
  - typedef enum dir_e {DIR_DOWN=0, DIR_UP=1};
  - typedef enum mode_e {MODE_WRAP=0, MODE_SAT=1};
  - a localparam for the default PSC_W.
- Sub-module counter_prescaler:
  - Parameter PSC_W.
  - Ports clk, rst, en, clr, prescale, tick.
  - Instantiated once. The top holds the count, boundary, tc, ovf and compare logic.

Test Plan:
- Reset and free count: WIDTH=5, MAX_VAL=31, prescale=0, dir=1, sat=0, en=1, rst low 2 cycles then high.
  - count 0,1,…,31,0.
  - tc high exactly one cycle with count==0 after the wrap.
  - ovf=1 and stays set.
- Modulo-10 down wrap: MAX_VAL=9, load 2, dir=0, prescale=0.
  - count 2,1,0,9,8.
  - tc pulses with count==9.
  - ovf_clr pulse → ovf=0 next cycle.
- Saturate: MAX_VAL=31, sat=1, load 30, dir=1.
  - count 30,31,31,31.
  - tc pulses each tick at 31.
  - Pulsing ovf_clr and reaching the boundary in the same cycle leaves ovf=1.
- Prescaler: prescale=3, en=1, from count 0.
  - count increments every 4th cycle: 0,0,0,0,1.
  - Holding en=0 for 5 cycles mid-period freezes count and phase.
  - Changing prescale 3→1 while psc_cnt=2 ticks on the next enabled cycle.
- Load priority and clamp: MAX_VAL=9, load=1 with load_val=20 while a tick is due.
  - count=9, no step, tc=0.
  - Asserting rst=0 in the same cycle as load instead yields count=0.
- Compare: cmp_val=5, count up from 0.
  - cmp_match high only while count==5.
  - Changing cmp_val to the current count asserts cmp_match in the same cycle.
